// File: rtl/exu_mul_arb.sv
// exu_mul_arb: two-requester arbiter in front of a 3-cycle pipelined multiplier.
//
// Requester 0 is the core pipeline and requester 1 is the auxiliary unit.
// The block grants at most one request per cycle and drives the multiplier
// packet combinationally from the winner. A 3-stage {valid, id, tag} tracker
// follows each operation through the multiplier and steers mul_out back to
// its owner.
//
// Build option:
//   RV_MUL_ARB_RR_EN  defined   -> round-robin arbitration with a 1-bit pointer.
//                     undefined -> requester 0 has fixed priority. Requester 1
//                                  is forced to win after STARVE_MAX
//                                  consecutive losses.
//
// Ports:
//   clk, rst_l        clock and synchronous active-low reset
//   freeze            pipeline freeze (shared with the multiplier)
//   reqN_*            request handshake, operands, sign/low select and tag
//   flushN            kill all in-flight operations of requester N
//   mul_*             multiplier packet out, mul_out result in
//   rspN_valid/data/tag  single-cycle response to requester N
//   busy              any tracker stage valid
module exu_mul_arb #(
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned STARVE_MAX = 7
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             freeze,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req0_rs1_sign,
  input  logic             req0_rs2_sign,
  input  logic             req0_low,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             flush0,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic             req1_rs1_sign,
  input  logic             req1_rs2_sign,
  input  logic             req1_low,
  input  logic [TAG_W-1:0] req1_tag,
  input  logic             flush1,

  output logic             mul_valid,
  output logic             mul_rs1_sign,
  output logic             mul_rs2_sign,
  output logic             mul_low,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [31:0]      mul_out,

  output logic             rsp0_valid,
  output logic [31:0]      rsp0_data,
  output logic [TAG_W-1:0] rsp0_tag,

  output logic             rsp1_valid,
  output logic [31:0]      rsp1_data,
  output logic [TAG_W-1:0] rsp1_tag,

  output logic             busy
);

  typedef struct packed {
    logic             valid;
    logic             id;
    logic [TAG_W-1:0] tag;
  } trk_t;

  trk_t trk_q [3];
  trk_t trk_d [3];

  logic elig0;
  logic elig1;
  logic gnt0;
  logic gnt1;

  // Eligibility is gated by reset so no grant can leak out while rst_l is low.
  always_comb begin
    elig0 = rst_l & ~freeze & req0_valid & ~flush0;
    elig1 = rst_l & ~freeze & req1_valid & ~flush1;
  end

`ifdef RV_MUL_ARB_RR_EN
  // ptr_q names the preferred requester. It only moves on a grant, so a
  // frozen cycle leaves it untouched.
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    ptr_d = ptr_q;
    if (elig0 && elig1) begin
      gnt0 = ~ptr_q;
      gnt1 = ptr_q;
    end else begin
      gnt0 = elig0;
      gnt1 = elig1;
    end
    if (gnt0) begin
      ptr_d = 1'b1;
    end else if (gnt1) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;

  // The counter advances only on a real loss: requester 1 was eligible but
  // did not win. Frozen or flushed cycles hold it. Dropping req1_valid clears it.
  always_comb begin
    gnt1         = elig1 & (~elig0 | (starve_cnt_q == STARVE_LIM));
    gnt0         = elig0 & ~gnt1;
    starve_cnt_d = starve_cnt_q;
    if (!req1_valid || gnt1) begin
      starve_cnt_d = '0;
    end else if (elig1 && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  always_comb begin
    req0_ready   = gnt0;
    req1_ready   = gnt1;
    mul_valid    = gnt0 | gnt1;
    mul_a        = gnt1 ? req1_a        : req0_a;
    mul_b        = gnt1 ? req1_b        : req0_b;
    mul_rs1_sign = gnt1 ? req1_rs1_sign : req0_rs1_sign;
    mul_rs2_sign = gnt1 ? req1_rs2_sign : req0_rs2_sign;
    mul_low      = gnt1 ? req1_low      : req0_low;
  end

  // Shift first, then apply the flush to the post-shift image. This kills a
  // flushed entry wherever it lands, including while the tracker is frozen.
  // A new entry never carries a flushed id because grant excludes flushN.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      trk_d[i] = trk_q[i];
    end
    if (!freeze) begin
      trk_d[0].valid = gnt0 | gnt1;
      trk_d[0].id    = gnt1;
      trk_d[0].tag   = gnt1 ? req1_tag : req0_tag;
      trk_d[1]       = trk_q[0];
      trk_d[2]       = trk_q[1];
    end
    for (int unsigned i = 0; i < 3; i++) begin
      if ((flush0 && !trk_d[i].id) || (flush1 && trk_d[i].id)) begin
        trk_d[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      for (int unsigned i = 0; i < 3; i++) begin
        trk_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        trk_q[i] <= trk_d[i];
      end
    end
  end

  always_comb begin
    rsp0_valid = rst_l & trk_q[2].valid & ~trk_q[2].id & ~freeze & ~flush0;
    rsp1_valid = rst_l & trk_q[2].valid &  trk_q[2].id & ~freeze & ~flush1;
    rsp0_data  = mul_out;
    rsp1_data  = mul_out;
    rsp0_tag   = trk_q[2].tag;
    rsp1_tag   = trk_q[2].tag;
    busy       = rst_l & (trk_q[0].valid | trk_q[1].valid | trk_q[2].valid);
  end

endmodule

// File: tb/tb_exu_mul_arb.sv
module tb_exu_mul_arb;

  localparam int SM = 7;

  logic        clk;
  logic        rst_l;
  logic        freeze;
  logic        req0_valid, req0_ready, req0_rs1_sign, req0_rs2_sign, req0_low, flush0;
  logic [31:0] req0_a, req0_b;
  logic [3:0]  req0_tag;
  logic        req1_valid, req1_ready, req1_rs1_sign, req1_rs2_sign, req1_low, flush1;
  logic [31:0] req1_a, req1_b;
  logic [3:0]  req1_tag;
  logic        mul_valid, mul_rs1_sign, mul_rs2_sign, mul_low;
  logic [31:0] mul_a, mul_b, mul_out;
  logic        rsp0_valid, rsp1_valid, busy;
  logic [31:0] rsp0_data, rsp1_data;
  logic [3:0]  rsp0_tag, rsp1_tag;

  int n_vec = 0;
  int n_err = 0;

  exu_mul_arb #(.TAG_W(4), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_l(rst_l), .freeze(freeze),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_rs1_sign(req0_rs1_sign), .req0_rs2_sign(req0_rs2_sign), .req0_low(req0_low),
    .req0_tag(req0_tag), .flush0(flush0),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_rs1_sign(req1_rs1_sign), .req1_rs2_sign(req1_rs2_sign), .req1_low(req1_low),
    .req1_tag(req1_tag), .flush1(flush1),
    .mul_valid(mul_valid), .mul_rs1_sign(mul_rs1_sign), .mul_rs2_sign(mul_rs2_sign),
    .mul_low(mul_low), .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_tag(rsp1_tag),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b,
                                       input logic sa, input logic sb, input logic lo);
    logic [63:0] ea, eb, p;
    ea = sa ? {{32{a[31]}}, a} : {32'h0, a};
    eb = sb ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return lo ? p[31:0] : p[63:32];
  endfunction

  // Stand-in for the 3-stage multiplier: it holds under freeze, like the real one.
  logic [31:0] mp [3];
  always @(posedge clk) begin
    if (!freeze) begin
      mp[0] <= mul_valid ? prod(mul_a, mul_b, mul_rs1_sign, mul_rs2_sign, mul_low) : 32'hdead_beef;
      mp[1] <= mp[0];
      mp[2] <= mp[1];
    end
  end
  assign mul_out = mp[2];

  task automatic idle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    freeze = 1'b0; flush0 = 1'b0; flush1 = 1'b0;
  endtask

  task automatic rnd_ops();
    req0_a = $urandom; req0_b = $urandom; req0_tag = 4'($urandom);
    req0_rs1_sign = 1'($urandom); req0_rs2_sign = 1'($urandom); req0_low = 1'($urandom);
    req1_a = $urandom; req1_b = $urandom; req1_tag = 4'($urandom);
    req1_rs1_sign = 1'($urandom); req1_rs2_sign = 1'($urandom); req1_low = 1'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_l = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    rst_l = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rnd_ops();
      req0_valid = 1'b1; req1_valid = 1'b1; freeze = 1'b0; flush0 = 1'b0; flush1 = 1'b0;
      #2;
      obs = {req0_ready, req1_ready, mul_valid, rsp0_valid, rsp1_valid, busy};
      n_vec++;
      if (obs !== 6'b0) begin
        n_err++;
        $display("FAIL reset_outputs cycle %0d: got %b want 000000", c, obs);
      end
    end
    idle();
  endtask

  task automatic test_signed();
    do_reset();
    @(negedge clk);
    idle();
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'h2;
    req0_rs1_sign = 1'b1; req0_rs2_sign = 1'b1; req0_low = 1'b1; req0_tag = 4'd3;
    #2;
    n_vec++;
    if ({req0_ready, req1_ready, mul_valid} !== 3'b101) begin
      n_err++;
      $display("FAIL signed_grant: got %b want 101", {req0_ready, req1_ready, mul_valid});
    end
    n_vec++;
    if ({mul_a, mul_b, mul_rs1_sign, mul_rs2_sign, mul_low} !== {32'hFFFF_FFFF, 32'h2, 3'b111}) begin
      n_err++;
      $display("FAIL signed_packet: got %h %h %b%b%b", mul_a, mul_b, mul_rs1_sign, mul_rs2_sign, mul_low);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      idle();
      #2;
      n_vec++;
      if ({rsp0_valid, rsp1_valid, busy} !== {(k == 3), 1'b0, (k <= 3)}) begin
        n_err++;
        $display("FAIL signed_timing T+%0d: rsp0/rsp1/busy got %b%b%b want %b0%b",
                 k, rsp0_valid, rsp1_valid, busy, (k == 3), (k <= 3));
      end
      if (k == 3) begin
        n_vec++;
        if (rsp0_data !== 32'hFFFF_FFFE || rsp0_tag !== 4'd3) begin
          n_err++;
          $display("FAIL signed_result: got %h tag %0d want fffffffe tag 3", rsp0_data, rsp0_tag);
        end
      end
    end
  endtask

  task automatic test_arbitration();
    logic [11:0] exp2;
    logic [11:0] v1;
    logic        e1;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      idle(); rnd_ops();
      req0_valid = 1'b1; req1_valid = 1'b1;
      #2;
`ifdef RV_MUL_ARB_RR_EN
      e1 = (k % 2 == 0);
`else
      e1 = (k % 8 == 0);
`endif
      n_vec++;
      if ({req1_ready, req0_ready} !== {e1, ~e1} || mul_a !== (e1 ? req1_a : req0_a)) begin
        n_err++;
        $display("FAIL arb_contest cycle %0d: ready1/ready0 %b%b mul_a %h want %b%b %h",
                 k, req1_ready, req0_ready, mul_a, e1, ~e1, e1 ? req1_a : req0_a);
      end
    end
    // Three contests, one cycle with req1 idle, then eight contests.
    v1 = 12'b1111_1111_0111;
`ifdef RV_MUL_ARB_RR_EN
    exp2 = 12'b0101_0101_0010;
`else
    exp2 = 12'b1000_0000_0000;
`endif
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      idle(); rnd_ops();
      req0_valid = 1'b1; req1_valid = v1[k];
      #2;
      e1 = exp2[k];
      n_vec++;
      if ({req1_ready, req0_ready} !== {e1, ~e1}) begin
        n_err++;
        $display("FAIL arb_starve_clear step %0d: ready1/ready0 %b%b want %b%b",
                 k, req1_ready, req0_ready, e1, ~e1);
      end
    end
  endtask

  task automatic test_freeze();
    logic [31:0] ep;
    logic [3:0]  et;
    do_reset();
    @(negedge clk);
    idle(); rnd_ops();
    req1_valid = 1'b1;
    ep = prod(req1_a, req1_b, req1_rs1_sign, req1_rs2_sign, req1_low);
    et = req1_tag;
    #2;
    n_vec++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL freeze_issue: ready1/ready0 %b%b want 10", req1_ready, req0_ready);
    end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      idle();
      freeze = (k == 1 || k == 2);
      req0_valid = freeze; req1_valid = freeze;
      #2;
      n_vec++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== {3'b000, (k == 5)}) begin
        n_err++;
        $display("FAIL freeze_timing T+%0d: r0 r1 rsp0 rsp1 %b%b%b%b want 000%b",
                 k, req0_ready, req1_ready, rsp0_valid, rsp1_valid, (k == 5));
      end
      if (k == 5) begin
        n_vec++;
        if (rsp1_data !== ep || rsp1_tag !== et) begin
          n_err++;
          $display("FAIL freeze_result: got %h tag %0d want %h tag %0d", rsp1_data, rsp1_tag, ep, et);
        end
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] ep;
    logic [3:0]  et;
    do_reset();
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      idle(); rnd_ops();
      req0_valid = (k == 0);
      req1_valid = (k == 1 || k == 2);
      flush0     = (k == 2);
      flush1     = (k == 5);
      if (k == 1) begin
        ep = prod(req1_a, req1_b, req1_rs1_sign, req1_rs2_sign, req1_low);
        et = req1_tag;
      end
      #2;
      n_vec++;
      if ({req0_ready, req1_ready} !== {(k == 0), (k == 1 || k == 2)}) begin
        n_err++;
        $display("FAIL flush_issue k=%0d: ready0/ready1 %b%b", k, req0_ready, req1_ready);
      end
      n_vec++;
      if ({rsp0_valid, rsp1_valid} !== {1'b0, (k == 4)}) begin
        n_err++;
        $display("FAIL flush_rsp k=%0d: rsp0/rsp1 %b%b want 0%b", k, rsp0_valid, rsp1_valid, (k == 4));
      end
      if (k == 4) begin
        n_vec++;
        if (rsp1_data !== ep || rsp1_tag !== et) begin
          n_err++;
          $display("FAIL flush_result: got %h tag %0d want %h tag %0d", rsp1_data, rsp1_tag, ep, et);
        end
      end
      if (k == 7) begin
        n_vec++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL flush_busy: got %b want 0", busy);
        end
      end
    end
  endtask

  task automatic test_back_to_back_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle(); rnd_ops();
      req0_valid = (k != 1); req1_valid = (k == 1);
      #2;
      n_vec++;
      if ({req0_ready, req1_ready} !== {(k != 1), (k == 1)}) begin
        n_err++;
        $display("FAIL b2b_issue k=%0d: ready0/ready1 %b%b", k, req0_ready, req1_ready);
      end
    end
    for (int k = 3; k <= 9; k++) begin
      @(negedge clk);
      idle();
      rst_l = (k != 3);
      #2;
      n_vec++;
      if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_inflight k=%0d: rsp0 rsp1 busy %b%b%b want 000", k, rsp0_valid, rsp1_valid, busy);
      end
    end
  endtask

  typedef struct {
    int          id;
    logic [3:0]  tag;
    logic [31:0] prod;
    int          age;
  } op_t;

  task automatic test_random();
    op_t         q[$];
    op_t         nq[$];
    op_t         op;
    int          losses;
    int          pref;
    int          g;
    bit          e0, e1, has_rsp;
    int          rid;
    logic [31:0] rdata;
    logic [3:0]  rtag;
    logic [66:0] wpkt;
    do_reset();
    losses = 0;
    pref   = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      rnd_ops();
      freeze     = ($urandom % 8 == 0);
      flush0     = ($urandom % 12 == 0);
      flush1     = ($urandom % 12 == 0);
      req0_valid = ($urandom % 4 != 0);
      req1_valid = ($urandom % 3 != 0);
      #2;
      e0 = req0_valid && !freeze && !flush0;
      e1 = req1_valid && !freeze && !flush1;
`ifdef RV_MUL_ARB_RR_EN
      if (e0 && e1) g = pref;
      else if (e0) g = 0;
      else if (e1) g = 1;
      else g = -1;
`else
      if (e1 && (!e0 || losses >= SM)) g = 1;
      else if (e0) g = 0;
      else g = -1;
`endif
      has_rsp = 1'b0; rid = 0; rdata = '0; rtag = '0;
      foreach (q[i]) begin
        if (q[i].age == 3 && !freeze && !(q[i].id == 0 ? flush0 : flush1)) begin
          has_rsp = 1'b1; rid = q[i].id; rdata = q[i].prod; rtag = q[i].tag;
        end
      end
      n_vec++;
      if ({req1_ready, req0_ready, mul_valid} !== {(g == 1), (g == 0), (g >= 0)}) begin
        n_err++;
        $display("FAIL rnd_grant cyc %0d: r1 r0 mv %b%b%b want grant %0d", c, req1_ready, req0_ready, mul_valid, g);
      end
      if (g >= 0) begin
        wpkt = (g == 1) ? {req1_a, req1_b, req1_rs1_sign, req1_rs2_sign, req1_low}
                        : {req0_a, req0_b, req0_rs1_sign, req0_rs2_sign, req0_low};
        n_vec++;
        if ({mul_a, mul_b, mul_rs1_sign, mul_rs2_sign, mul_low} !== wpkt) begin
          n_err++;
          $display("FAIL rnd_packet cyc %0d: got %h want %h", c,
                   {mul_a, mul_b, mul_rs1_sign, mul_rs2_sign, mul_low}, wpkt);
        end
      end
      n_vec++;
      if ({rsp0_valid, rsp1_valid, busy} !== {(has_rsp && rid == 0), (has_rsp && rid == 1), (q.size() != 0)}) begin
        n_err++;
        $display("FAIL rnd_rsp cyc %0d: rsp0 rsp1 busy %b%b%b want %b%b%b", c, rsp0_valid, rsp1_valid, busy,
                 (has_rsp && rid == 0), (has_rsp && rid == 1), (q.size() != 0));
      end
      if (has_rsp) begin
        n_vec++;
        if ((rid == 0 ? {rsp0_data, rsp0_tag} : {rsp1_data, rsp1_tag}) !== {rdata, rtag}) begin
          n_err++;
          $display("FAIL rnd_data cyc %0d rsp%0d: got %h/%h %h/%h want %h/%h", c, rid,
                   rsp0_data, rsp0_tag, rsp1_data, rsp1_tag, rdata, rtag);
        end
      end
      // Advance the model across the clock edge.
      nq.delete();
      foreach (q[i]) begin
        op = q[i];
        if (op.id == 0 ? flush0 : flush1) continue;
        if (!freeze) op.age++;
        if (op.age > 3) continue;
        nq.push_back(op);
      end
      if (g >= 0) begin
        op.id  = g;
        op.tag = (g == 1) ? req1_tag : req0_tag;
        op.prod = (g == 1) ? prod(req1_a, req1_b, req1_rs1_sign, req1_rs2_sign, req1_low)
                           : prod(req0_a, req0_b, req0_rs1_sign, req0_rs2_sign, req0_low);
        op.age = 1;
        nq.push_back(op);
      end
      q = nq;
`ifdef RV_MUL_ARB_RR_EN
      if (g >= 0) pref = 1 - g;
`else
      if (!req1_valid || g == 1) losses = 0;
      else if (e1 && losses < SM) losses++;
`endif
    end
    idle();
  endtask

  initial begin
    rst_l = 1'b0;
    idle();
    rnd_ops();
    test_reset();
    test_signed();
    test_arbitration();
    test_freeze();
    test_flush();
    test_back_to_back_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exu_mul_arb.md
EXU_MUL_ARB -- requirements
Module: exu_mul_arb

Interface
REQ-001 Parameter: TAG_W, 4, width of each requester's transaction tag.
REQ-002 Parameter: STARVE_MAX, 7, number of consecutive lost arbitrations after which requester 1 is forced to win (fixed-priority mode only).
REQ-003 clk  in  1  single clock for all state.
REQ-004 rst_l  in  1  reset; synchronous, active-low.
REQ-005 freeze  in  1  pipeline freeze; same signal that drives the multiplier's freeze input.
REQ-006 reqN_valid  in  1  request from requester N (N = 0, 1; 0 is core pipeline, 1 is auxiliary unit).
REQ-007 reqN_ready  out  1  request from requester N accepted this cycle.
REQ-008 reqN_a, reqN_b  in  32 each  operands from requester N.
REQ-009 reqN_rs1_sign, reqN_rs2_sign, reqN_low  in  1 each  signedness and low/high result select from requester N.
REQ-010 reqN_tag  in  TAG_W  transaction tag, returned with the response.
REQ-011 flushN  in  1  kill all in-flight operations of requester N.
REQ-012 mul_valid, mul_rs1_sign, mul_rs2_sign, mul_low  out  1 each  multiplier packet fields; the load-bypass fields are tied 0 at integration.
REQ-013 mul_a, mul_b  out  32 each  multiplier operands.
REQ-014 mul_out  in  32  multiplier result.
REQ-015 rspN_valid  out  1  single-cycle result pulse to requester N.
REQ-016 rspN_data  out  32  result data; rspN_tag  out  TAG_W  echoed tag.
REQ-017 busy  out  1  high while any tracker stage is valid.

Function
REQ-018 Issue requires all of: ~freeze, reqN_valid, ~flushN; at most one grant per cycle; reqN_ready = grant to N.
REQ-019 On grant, mul_valid=1 and mul_a/b/signs/low equal the granted requester's inputs in the same cycle; when there is no grant, mul_valid=0 and the data outputs are don't-care.
REQ-020 Tracker: 3-stage shift register of {valid, id, tag}.
  - Stage 1 loads the grant at the clock edge.
  - All stages advance only when freeze=0; under freeze all stages hold.
REQ-021 Latency: a request granted in cycle T produces rspN_valid in cycle T+3 with zero freeze cycles; each freeze cycle adds one cycle.
REQ-022 rspN_valid = stage3.valid & (stage3.id==N) & ~freeze & ~flushN; rspN_data = mul_out; rspN_tag = stage3.tag.
REQ-023 Responses have no back-pressure; there is one response per accepted, un-flushed request, in issue order.
REQ-024 flushN clears the valid bit of every tracker stage whose id==N at the next edge.
  - A flush in the response cycle suppresses that response.
  - flushN does not affect the other requester's entries.
REQ-025 Fixed-priority mode: requester 0 wins when both are valid.
  - starve_cnt counts cycles in which req1 is eligible but loses, saturating at STARVE_MAX.
  - When starve_cnt==STARVE_MAX, req1 wins the next contest.
  - starve_cnt clears on any req1 grant or when req1_valid=0.
REQ-026 Both requesters eligible while frozen: no grant, and no counter or pointer update.
REQ-027 Back-to-back issue every cycle is supported; up to 3 operations are in flight.

Reset
REQ-028 rst_l=0 at a clock edge clears all tracker valids, starve_cnt and the round-robin pointer (pointer reset value = requester 0).
REQ-029 While rst_l=0: reqN_ready=0, mul_valid=0, rspN_valid=0, busy=0.
REQ-030 Operations in flight when reset is applied are discarded; no response is produced for them after reset releases.

Configuration
REQ-031 Macro RV_MUL_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit pointer names the preferred requester.
  - After each grant the pointer moves to the other requester.
  - starve_cnt is not implemented.
REQ-032 Macro RV_MUL_ARB_RR_EN undefined: fixed priority with the starvation override of REQ-025.

Verification
REQ-033 req0 issues a=0xFFFFFFFF (signed), b=0x2, low=1, tag=3 at T -> rsp0_valid at T+3, data=0xFFFFFFFE, tag=3.
REQ-034 req0 and req1 both valid every cycle, fixed priority, STARVE_MAX=7 -> req1 granted on the 8th cycle; all other grants go to req0.
REQ-035 Same stimulus with RV_MUL_ARB_RR_EN defined -> grants alternate 0,1,0,1 starting with 0 after reset.
REQ-036 req1 issue at T, freeze high for cycles T+1..T+2 -> rsp1_valid exactly once, at T+5, with the correct product.
REQ-037 Issue req0 at T and req1 at T+1, flush0 at T+2 -> no rsp0; rsp1 at T+4.
REQ-038 Issue three ops, assert rst_l=0 at T+1 for one cycle -> no response is produced afterwards and busy=0 from T+2.
